// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter; the grant is held for a whole transaction.
// Define ARB_TIMEOUT_EN to add the ownership watchdog and the timeout_err pulse.
module bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_valid,
    input  logic              m0_mode,
    input  logic              m0_rready,
    output logic              m0_wready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_valid,
    input  logic              m1_mode,
    input  logic              m1_rready,
    output logic              m1_wready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_valid,
    output logic              s_mode,
    output logic              s_rready,
    input  logic              s_wready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        gnt,
    output logic              busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;     // 0: M0 was served last, 1: M1 was served last
    logic   xfer_done;
    logic   own_exit;
    logic   timeout_hit;

    // The owner's request is already muxed onto s_*, so completion is judged there.
    assign xfer_done = s_valid & (s_mode ? s_wready : (s_rvalid & s_rready));
    assign own_exit  = ~s_valid | xfer_done | timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       to_q;

    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th owned cycle; the pulse appears in the following IDLE cycle.
    assign timeout_hit = (state_q != IDLE) & s_valid & ~xfer_done & (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= timeout_hit;
        end
    end

    assign timeout_err = to_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_valid) begin
                    state_d = OWN0;
                end else if (m1_valid) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (own_exit) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (own_exit) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Responses are qualified by the owner's live request so nothing leaks after an abort.
    always_comb begin
        s_addr    = '0;
        s_wdata   = '0;
        s_valid   = 1'b0;
        s_mode    = 1'b0;
        s_rready  = 1'b0;
        m0_wready = 1'b0;
        m0_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_wready = 1'b0;
        m1_rvalid = 1'b0;
        m1_rdata  = '0;
        gnt       = 2'b00;
        case (state_q)
            OWN0: begin
                gnt       = 2'b01;
                s_addr    = m0_addr;
                s_wdata   = m0_wdata;
                s_valid   = m0_valid;
                s_mode    = m0_mode;
                s_rready  = m0_rready;
                m0_wready = m0_valid & m0_mode & s_wready;
                m0_rvalid = m0_valid & ~m0_mode & s_rvalid;
                m0_rdata  = s_rdata;
            end
            OWN1: begin
                gnt       = 2'b10;
                s_addr    = m1_addr;
                s_wdata   = m1_wdata;
                s_valid   = m1_valid;
                s_mode    = m1_mode;
                s_rready  = m1_rready;
                m1_wready = m1_valid & m1_mode & s_wready;
                m1_rvalid = m1_valid & ~m1_mode & s_rvalid;
                m1_rdata  = s_rdata;
            end
            default: ;
        endcase
        busy = |gnt;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level ownership model.
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] RD = 32'h12345678;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          mv[2], mm[2], mr[2];
    logic [AW-1:0] ma[2];
    logic [DW-1:0] md[2];
    logic          swr, srv;
    logic [DW-1:0] srd;

    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, s_wdata, m0_rdata, m1_rdata;
    logic m0_valid, m0_mode, m0_rready, m0_wready, m0_rvalid;
    logic m1_valid, m1_mode, m1_rready, m1_wready, m1_rvalid;
    logic s_valid, s_mode, s_rready;
    logic [1:0] gnt;
    logic busy;
    logic timeout_err;

    assign m0_valid = mv[0]; assign m0_mode = mm[0]; assign m0_rready = mr[0];
    assign m0_addr  = ma[0]; assign m0_wdata = md[0];
    assign m1_valid = mv[1]; assign m1_mode = mm[1]; assign m1_rready = mr[1];
    assign m1_addr  = ma[1]; assign m1_wdata = md[1];
`ifndef ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_valid(m0_valid), .m0_mode(m0_mode),
        .m0_rready(m0_rready), .m0_wready(m0_wready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_valid(m1_valid), .m1_mode(m1_mode),
        .m1_rready(m1_rready), .m1_wready(m1_wready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_valid(s_valid), .s_mode(s_mode),
        .s_rready(s_rready), .s_wready(swr), .s_rvalid(srv), .s_rdata(srd),
        .gnt(gnt), .busy(busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: who owns the bus, who was served last, how long the owner has held it.
    int owner, last_srv, held;
    bit to_due;
    logic [1:0]    e_gnt;
    logic          e_sv, e_sm, e_sr, e_to;
    logic [AW-1:0] e_sa;
    logic [DW-1:0] e_sd;
    logic          e_w[2], e_rv[2];
    logic [DW-1:0] e_rd[2];

    task automatic model_reset();
        owner = -1; last_srv = 1; held = 0; to_due = 1'b0;
    endtask

    task automatic model_expect();
        e_gnt = 2'b00; e_sv = 0; e_sm = 0; e_sr = 0; e_sa = '0; e_sd = '0;
        e_w = '{0, 0}; e_rv = '{0, 0}; e_rd = '{0, 0};
        e_to = to_due;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            e_sv = mv[owner]; e_sm = mm[owner]; e_sr = mr[owner];
            e_sa = ma[owner]; e_sd = md[owner];
            e_w[owner]  = mv[owner] & mm[owner] & swr;
            e_rv[owner] = mv[owner] & ~mm[owner] & srv;
            e_rd[owner] = srd;
        end
    endtask

    task automatic model_advance();
        bit done;
        to_due = 1'b0;
        if (owner < 0) begin
            held = 0;
            if (mv[0] && mv[1]) owner = (last_srv == 1) ? 0 : 1;
            else if (mv[0])     owner = 0;
            else if (mv[1])     owner = 1;
        end else begin
            done = mv[owner] && (mm[owner] ? swr : (srv && mr[owner]));
            held++;
            if (!mv[owner] || done) begin
                last_srv = owner; owner = -1;
            end else if (TO_EN && held == TO) begin
                last_srv = owner; owner = -1; to_due = 1'b1;
            end
        end
    endtask

    task automatic idle_inputs();
        mv = '{0, 0}; mm = '{0, 0}; mr = '{0, 0};
        swr = 0; srv = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  in;     // {m0v,m0m,m0r,m1v,m1m,m1r,swr,srv}
        logic [1:0]  gnt;
        logic        sv;
        logic [31:0] sa;
        logic [3:0]  resp;   // {m0_wready,m0_rvalid,m1_wready,m1_rvalid}
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [7:0] in, logic [1:0] g, logic sv, logic [31:0] sa,
                                logic [3:0] resp, logic [31:0] rd0, logic [31:0] rd1);
        vec_t v;
        v.in = in; v.gnt = g; v.sv = sv; v.sa = sa; v.resp = resp; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    initial begin
        int own_cnt, pulses, pulse_at;

        // Single write, single read, then six back-to-back reads from both masters.
        vt.push_back(mk(8'b110_000_00, 2'b00, 0, 0,      4'b0000, 0,  0));
        vt.push_back(mk(8'b110_000_00, 2'b01, 1, 'h100,  4'b0000, RD, 0));
        vt.push_back(mk(8'b110_000_00, 2'b01, 1, 'h100,  4'b0000, RD, 0));
        vt.push_back(mk(8'b110_000_10, 2'b01, 1, 'h100,  4'b1000, RD, 0));
        vt.push_back(mk(8'b000_000_00, 2'b00, 0, 0,      4'b0000, 0,  0));
        vt.push_back(mk(8'b000_101_00, 2'b00, 0, 0,      4'b0000, 0,  0));
        vt.push_back(mk(8'b000_101_00, 2'b10, 1, 'h20,   4'b0000, 0,  RD));
        vt.push_back(mk(8'b000_101_01, 2'b10, 1, 'h20,   4'b0001, 0,  RD));
        vt.push_back(mk(8'b000_000_00, 2'b00, 0, 0,      4'b0000, 0,  0));
        for (int k = 0; k < 3; k++) begin
            vt.push_back(mk(8'b101_101_01, 2'b00, 0, 0,     4'b0000, 0,  0));
            vt.push_back(mk(8'b101_101_01, 2'b01, 1, 'h100, 4'b0100, RD, 0));
            vt.push_back(mk(8'b101_101_01, 2'b00, 0, 0,     4'b0000, 0,  0));
            vt.push_back(mk(8'b101_101_01, 2'b10, 1, 'h20,  4'b0001, 0,  RD));
        end
        vt.push_back(mk(8'b000_000_00, 2'b00, 0, 0,      4'b0000, 0,  0));

        // Reset values, with a request pending to show nothing leaks through.
        idle_inputs();
        mv[0] = 1; mm[0] = 1; ma[0] = 'h100; md[0] = 32'hDEADBEEF;
        ma[1] = 'h20; md[1] = 32'h0BADF00D; srd = RD; swr = 1; srv = 1;
        #1;
        chk("rst_ctl", {gnt, busy, s_valid, s_mode, s_rready, m0_wready, m0_rvalid,
                        m1_wready, m1_rvalid, timeout_err}, 64'd0);
        chk("rst_bus", {s_addr, s_wdata}, 64'd0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        do_reset();

        for (int i = 0; i < vt.size(); i++) begin
            {mv[0], mm[0], mr[0], mv[1], mm[1], mr[1], swr, srv} = vt[i].in;
            #1;
            chk($sformatf("vec%0d.gnt", i), {gnt, busy}, {vt[i].gnt, |vt[i].gnt});
            chk($sformatf("vec%0d.s_valid", i), s_valid, vt[i].sv);
            chk($sformatf("vec%0d.s_addr", i), s_addr, vt[i].sa);
            chk($sformatf("vec%0d.resp", i), {m0_wready, m0_rvalid, m1_wready, m1_rvalid}, vt[i].resp);
            chk($sformatf("vec%0d.rdata", i), {m0_rdata, m1_rdata}, {vt[i].rd0, vt[i].rd1});
            @(negedge clk);
        end

        // Abort: M0 drops its read request before the slave answers.
        idle_inputs();
        mv[0] = 1; mr[0] = 1;
        #1 chk("abort_arb", gnt, 2'b00);
        @(negedge clk); #1;
        chk("abort_own", {gnt, s_valid}, {2'b01, 1'b1});
        @(negedge clk);
        mv[0] = 0;
        #1 chk("abort_sv", {gnt, s_valid, m0_rvalid}, {2'b01, 1'b0, 1'b0});
        @(negedge clk);
        srv = 1; srd = 32'hAAAA5555;
        #1 chk("abort_late_rsp", {gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata}, 69'd0);
        @(negedge clk);
        srv = 0; srd = RD;

        // Asynchronous reset while M1 owns the bus.
        mv[1] = 1; mm[1] = 0; mr[1] = 1;
        @(negedge clk); #1;
        chk("rstmid_pre", gnt, 2'b10);
        #2 rst_n = 1'b0;
        #1 chk("rstmid_async", {gnt, busy, s_valid}, {2'b00, 1'b0, 1'b0});
        mv[1] = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        mv[0] = 1; mv[1] = 1; mr = '{1, 1};
        #1 chk("rstmid_idle", gnt, 2'b00);
        @(negedge clk); #1;
        chk("rstmid_tie_m0", gnt, 2'b01);
        @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: a write the slave never accepts.
        do_reset();
        own_cnt = 0; pulses = 0; pulse_at = -1;
        for (int i = 0; i < 10; i++) begin
            mv[0] = (i < 9); mm[0] = 1; swr = 0;
            #1;
            if (gnt == 2'b01) own_cnt++;
            if (timeout_err) begin pulses++; pulse_at = i; end
            @(negedge clk);
        end
        chk("to_own_cycles", own_cnt, 8);
        chk("to_pulse_cnt", pulses, 1);
        chk("to_pulse_at", pulse_at, 9);
        mv[0] = 1; mv[1] = 1; mm = '{0, 0}; mr = '{1, 1};
        #1 chk("to_idle", gnt, 2'b00);
        @(negedge clk); #1;
        chk("to_next_gnt_m1", gnt, 2'b10);
        @(negedge clk);
`else
        own_cnt = 0; pulses = 0; pulse_at = 0;
`endif

        // Randomized traffic against the ownership model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(99) >= 85) begin
                    mv[m] = $urandom_range(1);
                    mm[m] = $urandom_range(1);
                    ma[m] = $urandom;
                    md[m] = $urandom;
                end
                mr[m] = ($urandom_range(3) != 0);
            end
            swr = ($urandom_range(9) < 3);
            srv = ($urandom_range(9) < 3);
            srd = $urandom;
            #1;
            model_expect();
            chk($sformatf("rnd%0d.ctl", c),
                {gnt, busy, s_valid, s_mode, s_rready, m0_wready, m0_rvalid, m1_wready, m1_rvalid, timeout_err},
                {e_gnt, |e_gnt, e_sv, e_sm, e_sr, e_w[0], e_rv[0], e_w[1], e_rv[1], e_to});
            chk($sformatf("rnd%0d.bus", c), {s_addr, s_wdata}, {e_sa, e_sd});
            chk($sformatf("rnd%0d.rdata", c), {m0_rdata, m1_rdata}, {e_rd[0], e_rd[1]});
            model_advance();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
